data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//   Data-memory responder for the core's load/store path; it drives mem_data for the writeback mux.
//   Accepts one request at a time from the core over a valid/ready handshake.
//   Performs byte-enabled word writes or word reads, then returns a response after a fixed latency.
//   It is the slave end of the core's memory-access interface.
// PARAMETERS
//   XLEN     32    data and address width
//   DEPTH    1024  number of XLEN-bit words; must be a power of two
//   LATENCY  2     cycles from request acceptance to rsp_valid; must be >=1
// PORTS
//   clk        in   1          single clock; all state updates on its rising edge
//   rst        in   1          synchronous, active-high reset
//   req_valid  in   1          core presents a request
//   req_ready  out  1          responder can accept; a transfer occurs when req_valid&&req_ready
//   req_we     in   1          1=store, 0=load
//   req_addr   in   XLEN       byte address
//   req_wdata  in   XLEN       store data
//   req_be     in   XLEN/8     store byte enables; bit i selects byte lane i (little-endian)
//   rsp_valid  out  1          one-cycle response pulse; no backpressure
//   rsp_rdata  out  XLEN       load data; 0 for stores and for errored accesses
//   rsp_err    out  1          access error; valid only when rsp_valid=1
// BEHAVIOUR
//   - Reset state: IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 while rst=1.
//   - Memory contents are not reset.
//   - FSM states and transitions:
//       IDLE: req_ready=1. On a transfer, go to WAIT if LATENCY>1, else to RESP.
//       WAIT: down-counter loaded with LATENCY-2 at accept. Go to RESP when the counter reaches 0.
//       RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in WAIT and RESP.
//   - Latency: a transfer accepted at edge T gives rsp_valid high in the cycle after edge T+LATENCY-1.
//     Next accept is possible at the edge after RESP, so throughput is one request per LATENCY+1 cycles.
//   - Access timing: the access happens on the accept edge.
//     Stores write the enabled lanes only. Loads capture the full word into the response register.
//     A load issued after a store's response always sees the stored data.
//   - Indexing: word index = req_addr[2 +: CLOG2(DEPTH)].
//     Out-of-range (req_addr >= DEPTH*4) -> no write, rdata=0, rsp_err=1.
//   - Boundaries:
//       req_be=0 on a store -> no change, rsp_err=0.
//       req_valid while busy is ignored; the core must hold the request until req_ready.
//       Reset mid-operation -> pending response dropped; a store accepted before reset stays written.
//       rst and req_valid in the same cycle -> no transfer.
// CONFIGURATION
//   DMEM_MISALIGN_ERR_EN
//     Defined: req_addr[1:0]!=0 -> no write, rdata=0, rsp_err=1.
//     Undefined: req_addr[1:0] ignored (word-aligned access); rsp_err is raised only for out-of-range.
// STRUCTURE
//   - defs.v (shared include): CLOG2 macro; state encodings DMEM_IDLE/DMEM_WAIT/DMEM_RESP as `define constants.
//   - One sub-module, dmem_array: DEPTH x XLEN storage with synchronous write.
//     It uses per-lane byte enables and a combinational read.
//   - data_mem holds the FSM, latency counter, address checks and response registers.
// TESTING
//   - Reset: hold rst 2 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0.
//     Release -> req_ready=1 the next cycle.
//   - Store then load, LATENCY=2:
//       store addr=0x10, wdata=0xDEADBEEF, be=4'hF -> rsp_valid 2 cycles after accept, rsp_err=0.
//       load 0x10 -> rsp_rdata=0xDEADBEEF.
//   - Byte enables: preload 0x11223344 at 0x20; store wdata=0xAABBCCDD, be=4'b0101.
//     Load 0x20 -> 0x11BB33DD.
//   - Out of range with DEPTH=1024: load 0x1000 -> rsp_err=1, rsp_rdata=0.
//     Store 0x1000 -> memory unchanged, rsp_err=1.
//   - Misaligned load 0x22:
//       with DMEM_MISALIGN_ERR_EN -> rsp_err=1, rdata=0.
//       without -> rsp_err=0, rdata = word at 0x20.
//   - Busy and reset:
//       hold req_valid during WAIT -> no second accept until after RESP.
//       assert rst in WAIT -> no rsp_valid ever; an accepted store remains visible on a later load.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data_mem load/store responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

  // The wait counter holds LATENCY-2 at most; keep at least one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency - 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x XLEN word storage: byte-lane synchronous write, combinational read.
module dmem_array #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic [XLEN/8-1:0]        i_be,
  output logic [XLEN-1:0]          o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < XLEN / 8; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: valid/ready request, fixed-latency one-cycle response.
// Optional macro DMEM_MISALIGN_ERR_EN flags req_addr[1:0] != 0 as an access error.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  input  logic [XLEN/8-1:0] i_req_be,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int unsigned   IdxW      = $clog2(DEPTH);
  localparam int unsigned   CntW      = cnt_width(LATENCY);
  localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [XLEN:0] AddrLimit = (XLEN + 1)'(DEPTH) << 2;

  dmem_state_e     r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_xfer;
  logic            w_err;
  logic            w_wr_en;
  logic [IdxW-1:0] w_idx;
  logic [XLEN-1:0] w_rd;

  assign w_xfer = i_req_valid && !i_rst && (r_state == StIdle);
  assign w_idx  = i_req_addr[2 +: IdxW];

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_err = ({1'b0, i_req_addr} >= AddrLimit) || (i_req_addr[1:0] != 2'b00);
`else
  assign w_err = ({1'b0, i_req_addr} >= AddrLimit);
`endif

  assign w_wr_en = w_xfer && i_req_we && !w_err;

  dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_idx   (w_idx),
    .i_wdata (i_req_wdata),
    .i_be    (i_req_be),
    .o_rdata (w_rd)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_req_ready = !i_rst;
        if (w_xfer) begin
          if (LATENCY > 1) begin
            w_state_next = StWait;
            w_cnt_next   = CntLoad;
          end else begin
            w_state_next = StResp;
          end
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StResp: begin
        o_rsp_valid  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Response data is captured on the accept edge, so later stores cannot disturb it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_xfer) begin
        r_rdata <= (!i_req_we && !w_err) ? w_rd : '0;
        r_err   <= w_err;
      end
    end
  end

  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: vector table plus reset/busy corner sequences.
module tb_data_mem;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_be    (req_be),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction; lat counts edges after the accept edge until rsp_valid.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat, output logic pulse_ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1;
    pulse_ok = !rsp_valid;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        pok;
  logic        seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b1, 32'h0,    32'h55AA55AA, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h55AA55AA, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    vecs[11] = '{1'b0, 32'h22,   32'h0,        4'h0, 32'h0,        1'b1};
`else
    vecs[11] = '{1'b0, 32'h22,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
`endif
    vecs[12] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset held two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {31'b0, req_ready}, 32'h0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release ready", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, pok);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LATENCY - 1));
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d pulse", i), {31'b0, pok}, 32'h1);
    end

    // Request held through WAIT/RESP: a second accept only after the response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    check("busy wait ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("busy resp valid", {31'b0, rsp_valid}, 32'h1);
    check("busy resp ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("busy idle ready", {31'b0, req_ready}, 32'h1);
    check("busy idle valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy second accept", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("busy second resp", {31'b0, rsp_valid}, 32'h1);
    check("busy second rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Reset while waiting: response dropped, accepted store persists.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h50;
    req_wdata = 32'h13579BDF;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("rst-in-wait ready", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst-in-wait no rsp", {31'b0, seen}, 32'h0);
    xfer(1'b0, 32'h50, 32'h0, 4'h0, rd, er, lat, pok);
    check("rst-in-wait store kept", rd, 32'h13579BDF);

    // rst together with req_valid: no transfer.
    xfer(1'b1, 32'h40, 32'h0, 4'hF, rd, er, lat, pok);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h00000077;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    check("rst+valid ready", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    seen      = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst+valid no rsp", {31'b0, seen}, 32'h0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, pok);
    check("rst+valid no write", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
